// File: rtl/dec_arb_pkg.sv
// Shared types and constants for the decoder round-robin arbiter.
// Holds the FSM state enum and the requester/select/hold-counter widths.
package dec_arb_pkg;
  localparam int NREQ   = 8;
  localparam int SEL_W  = 3;
  localparam int HOLD_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    GAP
  } state_t;
endpackage

// File: rtl/decoder_rr_pick.sv
// Combinational circular priority scan: first set req bit at or above ptr.
// Ports: req[7:0], ptr[2:0] in; pick[2:0] (chosen id), any (req != 0) out.
module decoder_rr_pick
  import dec_arb_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] pick,
  output logic             any
);

  logic [SEL_W-1:0] idx;

  // Scan from the farthest offset down so the closest one to ptr wins.
  always_comb begin
    idx  = '0;
    pick = '0;
    any  = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = ptr + SEL_W'(i);
      if (req[idx]) begin
        pick = idx;
        any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/decoder_rr_arbiter.sv
// Round-robin arbiter driving decoder_3_8 E/In with max hold and a gap cycle.
// Ports: clka, rst (async high), req[7:0] in; dec_E, dec_In[2:0], gnt_valid,
// gnt_id[2:0], timeout out. Optional DEC_ARB_LOCK_EN adds input lock.
module decoder_rr_arbiter
  import dec_arb_pkg::*;
#(
  parameter int MAX_HOLD = 4
) (
  input  logic             clka,
  input  logic             rst,
  input  logic [NREQ-1:0]  req,
`ifdef DEC_ARB_LOCK_EN
  input  logic             lock,
`endif
  output logic             dec_E,
  output logic [SEL_W-1:0] dec_In,
  output logic             gnt_valid,
  output logic [SEL_W-1:0] gnt_id,
  output logic             timeout
);

  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

  state_t            state_q, state_d;
  logic [SEL_W-1:0]  ptr_q, ptr_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              e_q, e_d;
  logic [SEL_W-1:0]  in_q, in_d;
  logic              to_q, to_d;
  logic [SEL_W-1:0]  pick;
  logic              any;
  logic              lock_on;
  logic              cur;
  logic              forced;

`ifdef DEC_ARB_LOCK_EN
  assign lock_on = lock;
`else
  assign lock_on = 1'b0;
`endif

  decoder_rr_pick u_pick (
    .req  (req),
    .ptr  (ptr_q),
    .pick (pick),
    .any  (any)
  );

  assign cur    = req[in_q];
  assign forced = (hold_q == HOLD_MAX) && !lock_on;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    e_d     = e_q;
    in_d    = in_q;
    to_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (any) begin
          in_d    = pick;
          e_d     = 1'b1;
          hold_d  = HOLD_W'(1);
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (!cur || forced) begin
          e_d     = 1'b0;
          ptr_d   = in_q + SEL_W'(1);
          state_d = GAP;
          // Request still up means the limit, not the requester, ended it.
          to_d    = cur;
        end else if (hold_q != HOLD_MAX) begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clka or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      hold_q  <= '0;
      e_q     <= 1'b0;
      in_q    <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      e_q     <= e_d;
      in_q    <= in_d;
      to_q    <= to_d;
    end
  end

  assign dec_E     = e_q;
  assign dec_In    = in_q;
  assign gnt_valid = e_q;
  assign gnt_id    = in_q;
  assign timeout   = to_q;

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// Directed-vector bench for decoder_rr_arbiter.
// Covers reset, single grant, fairness, wrap, limit release, optional lock.
module tb_decoder_rr_arbiter;
  import dec_arb_pkg::*;

  logic             clka;
  logic             rst;
  logic [NREQ-1:0]  req;
`ifdef DEC_ARB_LOCK_EN
  logic             lock;
`endif
  logic             dec_E;
  logic [SEL_W-1:0] dec_In;
  logic             gnt_valid;
  logic [SEL_W-1:0] gnt_id;
  logic             timeout;

  int n_vec;
  int n_bad;

  decoder_rr_arbiter #(.MAX_HOLD(4)) dut (
    .clka      (clka),
    .rst       (rst),
    .req       (req),
`ifdef DEC_ARB_LOCK_EN
    .lock      (lock),
`endif
    .dec_E     (dec_E),
    .dec_In    (dec_In),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id),
    .timeout   (timeout)
  );

  initial clka = 1'b0;
  always #5 clka = ~clka;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clka);
    #1;
  endtask

  task automatic chk_out(input string tag, input int e,
                         input int id, input int to);
    chk({tag, ".E"}, int'(dec_E), e);
    chk({tag, ".In"}, int'(dec_In), id);
    chk({tag, ".vld"}, int'(gnt_valid), e);
    chk({tag, ".id"}, int'(gnt_id), id);
    chk({tag, ".to"}, int'(timeout), to);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    req   = '0;
`ifdef DEC_ARB_LOCK_EN
    lock  = 1'b0;
`endif
    rst   = 1'b1;
    #2;
    chk_out("rst", 0, 0, 0);
    tick();
    rst = 1'b0;

    // 1: reset mid-grant
    req = 8'h08;
    tick();
    chk_out("t1.gnt", 1, 3, 0);
    #2 rst = 1'b1;
    #1;
    chk_out("t1.async", 0, 0, 0);
    req = '0;
    tick();
    rst = 1'b0;
    tick();
    tick();
    chk_out("t1.post", 0, 0, 0);

    // 2: single request held 2 cycles
    req = 8'h04;
    tick();
    chk_out("t2.c1", 1, 2, 0);
    tick();
    chk_out("t2.c2", 1, 2, 0);
    req = '0;
    tick();
    chk_out("t2.rel", 0, 2, 0);
    tick();
    chk_out("t2.idle", 0, 2, 0);
    // ptr should now be 3: bit 3 beats bit 0
    req = 8'h09;
    tick();
    chk_out("t2.ptr3", 1, 3, 0);
    req = '0;
    tick();
    tick();

    // 3: fairness with all requesting
    do_reset();
    req = 8'hFF;
    for (int g = 0; g < 9; g++) begin
      tick();
      chk_out($sformatf("t3.g%0d", g), 1, g % 8, 0);
      for (int h = 0; h < 3; h++) begin
        tick();
        chk_out($sformatf("t3.h%0d_%0d", g, h), 1, g % 8, 0);
      end
      tick();
      chk_out($sformatf("t3.rel%0d", g), 0, g % 8, 1);
      tick();
      chk_out($sformatf("t3.gap%0d", g), 0, g % 8, 0);
    end
    req = '0;

    // 4: wrap 7 -> 0; first walk ptr from 1 to 7
    tick();
    req = 8'h40;
    tick();
    chk_out("t4.g6", 1, 6, 0);
    req = '0;
    tick();
    tick();
    req = 8'h81;
    tick();
    chk_out("t4.g7", 1, 7, 0);
    tick();
    tick();
    tick();
    tick();
    chk_out("t4.to7", 0, 7, 1);
    tick();
    tick();
    chk_out("t4.g0", 1, 0, 0);
    req = '0;
    tick();
    chk_out("t4.rel0", 0, 0, 0);
    tick();

    // 5: request drops exactly at the hold limit
    req = 8'h20;
    tick();
    chk_out("t5.g5", 1, 5, 0);
    req = 8'h2F;
    tick();
    chk_out("t5.other", 1, 5, 0);
    tick();
    tick();
    req = '0;
    tick();
    chk_out("t5.rel", 0, 5, 0);
    tick();
    chk_out("t5.gap", 0, 5, 0);

`ifdef DEC_ARB_LOCK_EN
    // 6: lock suppresses the hold limit
    do_reset();
    lock = 1'b1;
    req  = 8'h01;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk_out($sformatf("t6.c%0d", c), 1, 0, 0);
    end
    lock = 1'b0;
    tick();
    chk_out("t6.rel", 0, 0, 1);
    req = '0;
    tick();
    chk_out("t6.gap", 0, 0, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule

// File: doc/decoder_rr_arbiter.md
Name: decoder_rr_arbiter

Overview:
Round-robin arbiter that shares the 3-to-8 decoder among 8 requesters.
- Picks one requester at a time and drives the decoder's enable (E) and select (In[2:0]) from registers, so exactly one decoder output line acts as that requester's grant.
- Enforces a maximum hold time and a one-cycle dead gap between grants, so two decoder outputs are never active back-to-back without a break.
- Sits directly in front of decoder_3_8 and is clocked from clkgen_1's clka domain.

Parameters:
- NREQ, 8, number of requesters; fixed at 8 to match the decoder outputs.
- SEL_W, 3, width of the select/grant id.
- MAX_HOLD, 4, maximum consecutive cycles a grant may be held (legal range 1..15).

Ports:
- clka  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  8  request vector; bit i = requester i.
- dec_E  out  1  decoder enable (to decoder_3_8 E).
- dec_In  out  3  decoder select (to decoder_3_8 In).
- gnt_valid  out  1  high while a grant is active; equals dec_E.
- gnt_id  out  3  id of the granted requester; equals dec_In.
- timeout  out  1  one-cycle pulse when a grant is revoked by MAX_HOLD.

Behaviour:
- Interface: one clock, clka; reset rst is asynchronous and active-high.
- Reset (asynchronous; outputs drop immediately, including mid-grant):
  - state=IDLE, dec_E=0, dec_In=0, gnt_valid=0, gnt_id=0, timeout=0.
  - ptr=0, hold_cnt=0.
- FSM states: IDLE, GRANT, GAP.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise pick the first set bit scanning circularly from ptr upward (ptr, ptr+1, ..., wrapping 7->0).
  - On the next edge: dec_In=pick, dec_E=1, hold_cnt=1, go to GRANT.
  - Latency: req sampled at edge n gives dec_E=1 after edge n.
- GRANT: release when req[gnt_id]==0, or when hold_cnt==MAX_HOLD (forced).
  - If neither condition holds, hold_cnt increments.
  - On release edge: dec_E=0, ptr=(gnt_id+1) mod 8 (wraps 7->0), go to GAP.
  - dec_In keeps its last value while dec_E=0.
  - timeout=1 for exactly one cycle only on a forced release while req[gnt_id] is still 1.
  - If req drops on the same cycle hold_cnt reaches MAX_HOLD, this counts as a normal release: timeout=0.
- GAP: exactly one cycle with dec_E=0, then go to IDLE unconditionally.
  - Minimum spacing between grants is therefore 2 dead cycles: the GAP cycle plus the IDLE sampling cycle.
- Requests are level signals. req changing on non-granted bits during GRANT has no effect.
- MAX_HOLD=1: every grant lasts one cycle. timeout pulses whenever req[gnt_id] is still high at release.
- hold_cnt is 4 bits and saturates; it is never compared past MAX_HOLD.
- A single persistent requester is re-granted after each GAP; round-robin order still applies.

Optional Feature:
- Macro: DEC_ARB_LOCK_EN.
- When defined:
  - Adds input port lock (1 bit).
  - While in GRANT with lock=1, the MAX_HOLD release is suppressed. hold_cnt saturates at MAX_HOLD and timeout does not fire.
  - A release from req dropping still applies.
  - If lock falls while hold_cnt==MAX_HOLD, a forced release with timeout occurs on the next edge.
- When undefined: no lock port; behaviour exactly as above.

Decomposition:
- Package dec_arb_pkg holds:
  - state enum {IDLE, GRANT, GAP};
  - constants NREQ=8, SEL_W=3, HOLD_W=4.
- One sub-module, decoder_rr_pick: purely combinational.
  - Inputs: req[7:0], ptr[2:0].
  - Outputs: pick[2:0], any.
  - Contains the circular priority scan.
- The top level holds the FSM, ptr, hold_cnt and the output registers.

Test Plan:
1. Reset mid-grant: grant id 3 active, assert rst between edges -> dec_E=0 and dec_In=0 immediately; after rst release with req=0, outputs stay 0.
2. Single request: req=8'b0000_0100 held 2 cycles, then dropped -> dec_E=1 and dec_In=2 for 2 cycles, 1 GAP cycle, ptr=3, timeout never set.
3. Round-robin fairness: req=8'hFF held, MAX_HOLD=4 -> grants 0,1,2,...,7,0 in order; each lasts 4 cycles, ends with a timeout pulse, then 1 dead GAP cycle.
4. Wrap: ptr=7, req=8'b1000_0001 -> grant 7 first, then 0; ptr wraps 7->0.
5. Simultaneous drop at limit: req[5] falls on the cycle hold_cnt==MAX_HOLD -> release with timeout=0.
6. DEC_ARB_LOCK_EN build: req=8'h01, lock=1 for 10 cycles -> grant 0 held 10 cycles with no timeout; lock falls -> forced release one edge later with a timeout pulse.
